// File: rtl/imm_parser.sv
// Streaming ASCII immediate parser: consumes one character per cycle and produces a
// range-checked two's-complement immediate from decimal, 0x-hex or negative literals.
module imm_parser #(
    parameter int IMM_WIDTH  = 32,
    parameter int LINE_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic [7:0]            char_in,
    input  logic                  char_valid_in,
    output logic                  char_ready_out,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [IMM_WIDTH-1:0]  imm_out,
    output logic                  err_out,
    output logic [LINE_WIDTH-1:0] line_out,
    output logic [7:0]            delim_out,
    output logic                  busy_out
);
    localparam int AW = IMM_WIDTH + 5;
    localparam logic [AW-1:0] LIM_POS = (AW'(1) << IMM_WIDTH) - AW'(1);
    localparam logic [AW-1:0] LIM_NEG = AW'(1) << (IMM_WIDTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FIRST, S_SIGNED, S_ZERO, S_HEXSTART, S_HEX, S_DEC, S_ERR, S_DONE
    } state_t;

    state_t             state, state_d;
    logic [IMM_WIDTH:0] acc;
    logic               neg, ovf;

    logic               is_delim, is_dec, is_nz, is_hex, is_x, is_minus;
    logic [3:0]         dval;
    logic               consume, start_acc, take_digit, use_hex, set_neg, fin, fin_err;
    logic [AW-1:0]      acc_ext, dig_ext, acc_nxt, limit;
    logic [IMM_WIDTH-1:0] acc_lo, mag;

    assign char_ready_out = (state != S_IDLE) && (state != S_DONE);
    assign out_valid_out  = (state == S_DONE);
    assign busy_out       = (state != S_IDLE);
    assign consume        = char_valid_in && char_ready_out;

    // Character classification; letter digits map via low nibble + 9 ('a'/'A' -> 10).
    always_comb begin
        is_delim = (char_in == 8'h20) || (char_in == 8'h2C) || (char_in == 8'h28) ||
                   (char_in == 8'h29) || (char_in == 8'h0A) || (char_in == 8'h00);
        is_dec   = (char_in >= 8'h30) && (char_in <= 8'h39);
        is_nz    = (char_in >= 8'h31) && (char_in <= 8'h39);
        is_hex   = is_dec || ((char_in >= 8'h61) && (char_in <= 8'h66)) ||
                   ((char_in >= 8'h41) && (char_in <= 8'h46));
        is_x     = (char_in == 8'h78) || (char_in == 8'h58);
        is_minus = (char_in == 8'h2D);
        dval     = is_dec ? char_in[3:0] : char_in[3:0] + 4'd9;
    end

    always_comb begin
        acc_ext = {4'b0000, acc};
        dig_ext = {{(AW-4){1'b0}}, dval};
        acc_nxt = use_hex ? (acc_ext << 4) + dig_ext
                          : (acc_ext << 3) + (acc_ext << 1) + dig_ext;
        limit   = neg ? LIM_NEG : LIM_POS;
        acc_lo  = acc[IMM_WIDTH-1:0];
        mag     = neg ? (~acc_lo) + IMM_WIDTH'(1) : acc_lo;
    end

    always_comb begin
        state_d    = state;
        take_digit = 1'b0;
        use_hex    = 1'b0;
        set_neg    = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        start_acc  = 1'b0;
        case (state)
            S_IDLE: if (start_in) begin
                start_acc = 1'b1;
                state_d   = S_FIRST;
            end
            S_FIRST: if (consume) begin
                if (is_minus)           begin state_d = S_SIGNED; set_neg = 1'b1; end
                else if (char_in == 8'h30) state_d = S_ZERO;
                else if (is_nz)         begin state_d = S_DEC; take_digit = 1'b1; end
                else if (is_delim)      begin fin = 1'b1; fin_err = 1'b1; end
                else                    state_d = S_ERR;
            end
            S_SIGNED: if (consume) begin
                if (char_in == 8'h30)   state_d = S_ZERO;
                else if (is_nz)         begin state_d = S_DEC; take_digit = 1'b1; end
                else if (is_delim)      begin fin = 1'b1; fin_err = 1'b1; end
                else                    state_d = S_ERR;
            end
            S_ZERO: if (consume) begin
                if (is_x)               state_d = S_HEXSTART;
                else if (is_dec)        begin state_d = S_DEC; take_digit = 1'b1; end
                else if (is_delim)      fin = 1'b1;
                else                    state_d = S_ERR;
            end
            S_HEXSTART, S_HEX: if (consume) begin
                use_hex = 1'b1;
                if (is_hex)             begin state_d = S_HEX; take_digit = 1'b1; end
                else if (is_delim)      begin fin = 1'b1; fin_err = (state == S_HEXSTART) || ovf; end
                else                    state_d = S_ERR;
            end
            S_DEC: if (consume) begin
                if (is_dec)             take_digit = 1'b1;
                else if (is_delim)      begin fin = 1'b1; fin_err = ovf; end
                else                    state_d = S_ERR;
            end
            S_ERR: if (consume && is_delim) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
            S_DONE: if (out_ready_in) begin
                start_acc = start_in;
                state_d   = start_in ? S_FIRST : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) state_d = S_DONE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            acc       <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            imm_out   <= '0;
            err_out   <= 1'b0;
            line_out  <= '0;
            delim_out <= '0;
        end else begin
            state <= state_d;
            if (start_acc) begin
                line_out <= line_in;
                acc      <= '0;
                neg      <= 1'b0;
                ovf      <= 1'b0;
            end
            if (set_neg) neg <= 1'b1;
            // Overflow is sticky and freezes the accumulator for the rest of the token.
            if (take_digit && !ovf) begin
                if (acc_nxt > limit) ovf <= 1'b1;
                else                 acc <= acc_nxt[IMM_WIDTH:0];
            end
            if (fin) begin
                delim_out <= char_in;
                err_out   <= fin_err;
                imm_out   <= fin_err ? '0 : mag;
            end
        end
    end
endmodule

// File: tb/tb_imm_parser.sv
// Directed bench for imm_parser: one 12-bit and one 32-bit instance share the input stream.
module tb_imm_parser;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cvalid = 1'b0, oready = 1'b0;
    logic [7:0] ln = '0, ch = '0;

    logic cr12, v12, e12, b12, cr32, v32, e32, b32;
    logic [11:0] imm12;
    logic [31:0] imm32;
    logic [7:0]  l12, d12, l32, d32;

    int n_pass = 0, n_total = 0, n_cons = 0;

    imm_parser #(.IMM_WIDTH(12), .LINE_WIDTH(8)) dut12 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .line_in(ln), .char_in(ch),
        .char_valid_in(cvalid), .char_ready_out(cr12), .out_valid_out(v12),
        .out_ready_in(oready), .imm_out(imm12), .err_out(e12), .line_out(l12),
        .delim_out(d12), .busy_out(b12));

    imm_parser #(.IMM_WIDTH(32), .LINE_WIDTH(8)) dut32 (
        .clk_in(clk), .rst_in(rst), .start_in(start), .line_in(ln), .char_in(ch),
        .char_valid_in(cvalid), .char_ready_out(cr32), .out_valid_out(v32),
        .out_ready_in(oready), .imm_out(imm32), .err_out(e32), .line_out(l32),
        .delim_out(d32), .busy_out(b32));

    wire [29:0] r12 = {v12, e12, imm12, d12, l12};
    wire [49:0] r32 = {v32, e32, imm32, d32, l32};

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && cvalid && cr32) n_cons++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_parse(input logic [7:0] line);
        start = 1'b1; ln = line;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            int g = 0;
            ch = s[i]; cvalid = 1'b1;
            while (!cr32 && g < 20) begin @(posedge clk); #1; g++; end
            if (g >= 20) begin
                n_total++;
                $display("FAIL feed_timeout: char_ready stayed 0, required 1 for char %0d of '%s'", i, s);
                cvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gap > 0) begin
                cvalid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        cvalid = 1'b0;
    endtask

    task automatic ack();
        oready = 1'b1;
        @(posedge clk); #1;
        oready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_total++; if ({cr32, v32, imm32, e32, l32, d32, b32} !== '0)
            $display("FAIL reset32: got %h required 0", {cr32, v32, imm32, e32, l32, d32, b32}); else n_pass++;
        n_total++; if ({cr12, v12, imm12, e12, l12, d12, b12} !== '0)
            $display("FAIL reset12: got %h required 0", {cr12, v12, imm12, e12, l12, d12, b12}); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hex_basic();
        start_parse(8'd5);
        n_total++; if ({cr32, b32, v32} !== 3'b110)
            $display("FAIL start_ready: got %b required 110", {cr32, b32, v32}); else n_pass++;
        feed("0x1F,", 0);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'h1F, 8'h2C, 8'd5})
            $display("FAIL hex32: got %h required %h", r32, {1'b1, 1'b0, 32'h1F, 8'h2C, 8'd5}); else n_pass++;
        n_total++; if (r12 !== {1'b1, 1'b0, 12'h1F, 8'h2C, 8'd5})
            $display("FAIL hex12: got %h required %h", r12, {1'b1, 1'b0, 12'h1F, 8'h2C, 8'd5}); else n_pass++;
        ack();
        n_total++; if ({v32, b32} !== 2'b00)
            $display("FAIL ack_idle: got %b required 00", {v32, b32}); else n_pass++;
    endtask

    task automatic test_range12();
        start_parse(8'd10); feed("-2048 ", 0);
        n_total++; if (r12 !== {1'b1, 1'b0, 12'h800, 8'h20, 8'd10})
            $display("FAIL neg2048_12: got %h required %h", r12, {1'b1, 1'b0, 12'h800, 8'h20, 8'd10}); else n_pass++;
        n_total++; if (r32 !== {1'b1, 1'b0, 32'hFFFFF800, 8'h20, 8'd10})
            $display("FAIL neg2048_32: got %h required %h", r32, {1'b1, 1'b0, 32'hFFFFF800, 8'h20, 8'd10}); else n_pass++;
        ack();
        start_parse(8'd11); feed("-2049 ", 0);
        n_total++; if (r12 !== {1'b1, 1'b1, 12'h000, 8'h20, 8'd11})
            $display("FAIL neg2049_12: got %h required %h", r12, {1'b1, 1'b1, 12'h000, 8'h20, 8'd11}); else n_pass++;
        n_total++; if (r32 !== {1'b1, 1'b0, 32'hFFFFF7FF, 8'h20, 8'd11})
            $display("FAIL neg2049_32: got %h required %h", r32, {1'b1, 1'b0, 32'hFFFFF7FF, 8'h20, 8'd11}); else n_pass++;
        ack();
        start_parse(8'd12); feed("4095)", 0);
        n_total++; if (r12 !== {1'b1, 1'b0, 12'hFFF, 8'h29, 8'd12})
            $display("FAIL pos4095_12: got %h required %h", r12, {1'b1, 1'b0, 12'hFFF, 8'h29, 8'd12}); else n_pass++;
        ack();
        start_parse(8'd13); feed("4096)", 0);
        n_total++; if (r12 !== {1'b1, 1'b1, 12'h000, 8'h29, 8'd13})
            $display("FAIL pos4096_12: got %h required %h", r12, {1'b1, 1'b1, 12'h000, 8'h29, 8'd13}); else n_pass++;
        n_total++; if (r32 !== {1'b1, 1'b0, 32'h1000, 8'h29, 8'd13})
            $display("FAIL pos4096_32: got %h required %h", r32, {1'b1, 1'b0, 32'h1000, 8'h29, 8'd13}); else n_pass++;
        ack();
    endtask

    task automatic test_range32();
        start_parse(8'd20); feed("0xFFFFFFFF\n", 0);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'hFFFFFFFF, 8'h0A, 8'd20})
            $display("FAIL hexmax32: got %h required %h", r32, {1'b1, 1'b0, 32'hFFFFFFFF, 8'h0A, 8'd20}); else n_pass++;
        n_total++; if (r12 !== {1'b1, 1'b1, 12'h000, 8'h0A, 8'd20})
            $display("FAIL hexmax12: got %h required %h", r12, {1'b1, 1'b1, 12'h000, 8'h0A, 8'd20}); else n_pass++;
        ack();
        start_parse(8'd21); feed("4294967296\n", 0);
        n_total++; if (r32 !== {1'b1, 1'b1, 32'h0, 8'h0A, 8'd21})
            $display("FAIL dec2p32_32: got %h required %h", r32, {1'b1, 1'b1, 32'h0, 8'h0A, 8'd21}); else n_pass++;
        ack();
        start_parse(8'd22); feed("012 ", 0);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'd12, 8'h20, 8'd22})
            $display("FAIL lead0_32: got %h required %h", r32, {1'b1, 1'b0, 32'd12, 8'h20, 8'd22}); else n_pass++;
        n_total++; if (r12 !== {1'b1, 1'b0, 12'd12, 8'h20, 8'd22})
            $display("FAIL lead0_12: got %h required %h", r12, {1'b1, 1'b0, 12'd12, 8'h20, 8'd22}); else n_pass++;
        ack();
    endtask

    task automatic test_errors();
        int c0;
        c0 = n_cons;
        start_parse(8'd30); feed("12g4,", 0);
        n_total++; if (r32 !== {1'b1, 1'b1, 32'h0, 8'h2C, 8'd30})
            $display("FAIL badchar32: got %h required %h", r32, {1'b1, 1'b1, 32'h0, 8'h2C, 8'd30}); else n_pass++;
        n_total++; if (n_cons - c0 !== 5)
            $display("FAIL badchar_consumed: got %0d required 5", n_cons - c0); else n_pass++;
        ack();
        start_parse(8'd31); feed("0x)", 0);
        n_total++; if (r32 !== {1'b1, 1'b1, 32'h0, 8'h29, 8'd31})
            $display("FAIL empty_hex: got %h required %h", r32, {1'b1, 1'b1, 32'h0, 8'h29, 8'd31}); else n_pass++;
        ack();
        start_parse(8'd32); feed("-,", 0);
        n_total++; if (r32 !== {1'b1, 1'b1, 32'h0, 8'h2C, 8'd32})
            $display("FAIL lone_minus: got %h required %h", r32, {1'b1, 1'b1, 32'h0, 8'h2C, 8'd32}); else n_pass++;
        ack();
        start_parse(8'd33); feed("8(", 0);
        n_total++; if (r12 !== {1'b1, 1'b0, 12'd8, 8'h28, 8'd33})
            $display("FAIL paren12: got %h required %h", r12, {1'b1, 1'b0, 12'd8, 8'h28, 8'd33}); else n_pass++;
        ack();
        start_parse(8'd34); feed("--5 ", 0);
        n_total++; if (r32 !== {1'b1, 1'b1, 32'h0, 8'h20, 8'd34})
            $display("FAIL double_minus: got %h required %h", r32, {1'b1, 1'b1, 32'h0, 8'h20, 8'd34}); else n_pass++;
        ack();
    endtask

    task automatic test_stall();
        start_parse(8'd40); feed("0xaB,", 0);
        for (int i = 0; i < 3; i++) begin
            n_total++; if ({r32, cr32} !== {1'b1, 1'b0, 32'hAB, 8'h2C, 8'd40, 1'b0})
                $display("FAIL stall_hold%0d: got %h required %h", i, {r32, cr32}, {1'b1, 1'b0, 32'hAB, 8'h2C, 8'd40, 1'b0}); else n_pass++;
            @(posedge clk); #1;
        end
        ack();
    endtask

    task automatic test_back_to_back();
        start_parse(8'd1); feed("7 ", 0);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'd7, 8'h20, 8'd1})
            $display("FAIL b2b_first: got %h required %h", r32, {1'b1, 1'b0, 32'd7, 8'h20, 8'd1}); else n_pass++;
        oready = 1'b1; start = 1'b1; ln = 8'd2;
        @(posedge clk); #1;
        oready = 1'b0; start = 1'b0;
        n_total++; if ({v32, cr32, b32, l32} !== {1'b0, 1'b1, 1'b1, 8'd2})
            $display("FAIL b2b_restart: got %h required %h", {v32, cr32, b32, l32}, {1'b0, 1'b1, 1'b1, 8'd2}); else n_pass++;
        feed("0x10,", 0);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'h10, 8'h2C, 8'd2})
            $display("FAIL b2b_second: got %h required %h", r32, {1'b1, 1'b0, 32'h10, 8'h2C, 8'd2}); else n_pass++;
        ack();
    endtask

    task automatic test_gaps();
        start_parse(8'd50); feed("-123,", 2);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'hFFFFFF85, 8'h2C, 8'd50})
            $display("FAIL gaps32: got %h required %h", r32, {1'b1, 1'b0, 32'hFFFFFF85, 8'h2C, 8'd50}); else n_pass++;
        n_total++; if (r12 !== {1'b1, 1'b0, 12'hF85, 8'h2C, 8'd50})
            $display("FAIL gaps12: got %h required %h", r12, {1'b1, 1'b0, 12'hF85, 8'h2C, 8'd50}); else n_pass++;
        ack();
    endtask

    task automatic test_reset_mid();
        start_parse(8'd9); feed("0x12", 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if ({b32, cr32, v32, b12, cr12, v12} !== 6'b0)
            $display("FAIL midreset_idle: got %b required 000000", {b32, cr32, v32, b12, cr12, v12}); else n_pass++;
        repeat (3) @(posedge clk); #1;
        n_total++; if ({v32, v12} !== 2'b00)
            $display("FAIL midreset_noout: got %b required 00", {v32, v12}); else n_pass++;
        start_parse(8'd3); feed("99\n", 0);
        n_total++; if (r32 !== {1'b1, 1'b0, 32'h63, 8'h0A, 8'd3})
            $display("FAIL postreset: got %h required %h", r32, {1'b1, 1'b0, 32'h63, 8'h0A, 8'd3}); else n_pass++;
        ack();
    endtask

    initial begin
        test_reset();
        test_hex_basic();
        test_range12();
        test_range32();
        test_errors();
        test_stall();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imm_parser.md
# imm_parser

Streaming ASCII immediate parser for the assembler front end. It consumes one source character per cycle over a valid/ready handshake and accepts signed decimal, hex (`0x`/`0X`) and negative literals. It checks the value against a parametrised immediate width and returns the value, the terminating delimiter and the source line number, or an error flag. It sits between the line tokenizer and the instruction encoder, replacing per-character hex conversion with a full multi-digit, range-checked parse.

## Interface
- `IMM_WIDTH`, 32: width of the produced immediate (e.g. 12 for I-type, 20 for U-type).
- `LINE_WIDTH`, 8: width of the line-number tag.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: synchronous reset, active-high.
- `start_in` in 1: pulse that begins a parse. Ignored unless the block is IDLE, or is in DONE with the output handshake completing that cycle.
- `line_in` in LINE_WIDTH: line number, latched on an accepted `start_in`.
- `char_in` in 8: ASCII character.
- `char_valid_in` in 1: `char_in` is valid.
- `char_ready_out` out 1: the block will consume `char_in` this cycle.
- `out_valid_out` out 1: result available.
- `out_ready_in` in 1: consumer accepts the result.
- `imm_out` out IMM_WIDTH: parsed value, two's complement. 0 when `err_out` is 1.
- `err_out` out 1: parse or range error.
- `line_out` out LINE_WIDTH: latched `line_in`.
- `delim_out` out 8: the delimiter character that ended the token.
- `busy_out` out 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: waits for `start_in`.
  - FIRST: first character. `-` sets neg and goes to SIGNED; `0` goes to ZERO; 1-9 goes to DEC; delimiter goes to DONE with error; anything else goes to ERR.
  - SIGNED: after `-`. `0` goes to ZERO; 1-9 goes to DEC; delimiter goes to DONE with error; other goes to ERR.
  - ZERO: after a leading `0`. `x`/`X` goes to HEXSTART; 0-9 goes to DEC; delimiter goes to DONE with value 0.
  - HEXSTART: a hex digit goes to HEX; delimiter goes to DONE with error (`0x` with no digits).
  - HEX and DEC: accumulate digits. A delimiter goes to DONE.
  - ERR: consumes characters until a delimiter, then goes to DONE with `err_out`=1. This resyncs the stream.
- Delimiters: space 0x20, `,` 0x2C, `(` 0x28, `)` 0x29, newline 0x0A, NUL 0x00. The delimiter is consumed and reported in `delim_out`.
- Any non-digit, non-delimiter character in a digit state goes to ERR. `x` after a nonzero digit, or a second `-`, is an error.
- Digit sets:
  - Hex: 0-9, a-f, A-F (value 10-15).
  - Decimal: 0-9. A leading zero is allowed (`012` = 12).
- Arithmetic:
  - Unsigned magnitude accumulator, IMM_WIDTH+1 bits.
  - Hex: acc = acc·16 + d. Decimal: acc = (acc<<3) + (acc<<1) + d, computed at IMM_WIDTH+5 bits.
  - Sticky overflow flag is set if the full-width result exceeds the limit. The limit is 2^IMM_WIDTH − 1 when positive and 2^(IMM_WIDTH−1) when negative.
  - Once overflow is set, the accumulator holds its value.
  - Overflow at the delimiter produces a DONE error.
- Result: `imm_out` = neg ? −acc : acc, truncated to IMM_WIDTH. Positive values up to 2^IMM_WIDTH − 1 are legal, so bit patterns such as 0xFFF for 12-bit are accepted.
- DONE:
  - `out_valid_out`=1; all result outputs are held stable until `out_valid_out && out_ready_in`.
  - On that handshake the block returns to IDLE, or to FIRST if `start_in` is asserted in the same cycle (new line latched).
- `char_ready_out` = 1 exactly in FIRST, SIGNED, ZERO, HEXSTART, HEX, DEC and ERR.

## Timing
- Reset: state IDLE. `char_ready_out`, `out_valid_out`, `imm_out`, `err_out`, `line_out`, `delim_out` and `busy_out` are all 0. Reset mid-parse discards the token with no output.
- `start_in` accepted at cycle t: `char_ready_out`=1 and `busy_out`=1 from t+1.
- One character is consumed per cycle on `char_valid_in && char_ready_out`. A cycle with `char_valid_in`=0 changes no state.
- Delimiter consumed at cycle k: `out_valid_out`=1 and `char_ready_out`=0 from k+1. Latency from last character to result is 1 cycle.
- A token of n characters plus delimiter with no stalls takes n+1 consume cycles; the result appears on the next cycle.
- Handshake at cycle h: `out_valid_out`=0 at h+1. If `start_in` was accepted at h, `char_ready_out`=1 at h+1, giving back-to-back tokens with no bubble.
- Outputs are registered; `char_ready_out` is a function of state only, with no combinational path from `char_valid_in`.

## Test plan
- `start_in`, line 5, then "0x1F," → 1 cycle after `,`: `imm_out`=0x1F, `err_out`=0, `delim_out`=0x2C, `line_out`=5.
- IMM_WIDTH=12: "-2048 " → `imm_out`=0x800, `err_out`=0. "-2049 " → `err_out`=1, `imm_out`=0. "4095)" → 0xFFF. "4096)" → error.
- IMM_WIDTH=32: "0xFFFFFFFF\n" → 0xFFFFFFFF, no error. "4294967296\n" → error. "012 " → 12.
- "12g4," → `err_out`=1, `delim_out`=0x2C, with all 5 characters consumed. "0x)" → error with `delim_out`=0x29. "-," → error. "8(" → `imm_out`=8, `delim_out`=0x28.
- Hold `out_ready_in` low for 3 cycles in DONE → outputs stable, `char_ready_out`=0. Handshake together with `start_in` → next token parsed with no idle cycle. Gaps in `char_valid_in` → same results.
- `rst_in` pulsed mid-token ("0x12") → IDLE next cycle, no `out_valid_out`. A new token then parses correctly.
